// File: rtl/tlight_monitor.sv
// Passive checker for a UK traffic-light lamp bus: tracks the phase sequence,
// measures per-phase dwell, counts completed cycles and latches the first violation.
module tlight_monitor #(
    parameter int MAX_DWELL = 15,
    parameter int DW_W      = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             a,
    input  logic             g,
    output logic [2:0]       phase,
    output logic [DW_W-1:0]  dwell,
    output logic [CNT_W-1:0] cycles,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        S_UNSYNC    = 3'd0,
        S_RED       = 3'd1,
        S_RED_AMBER = 3'd2,
        S_GREEN     = 3'd3,
        S_AMBER     = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        E_NONE       = 2'd0,
        E_PATTERN    = 2'd1,
        E_TRANSITION = 2'd2,
        E_TIMEOUT    = 2'd3
    } err_t;

    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_DWELL);

    // The FSM state register is the phase output itself.
    phase_t state;
    phase_t pat;
    phase_t succ;
    logic   pat_legal;
    err_t   cause;

    initial begin : param_check
        // Elaboration-time guard only; no hardware.
    end

    always_comb begin
        pat       = S_UNSYNC;
        pat_legal = 1'b1;
        case ({r, a, g})
            3'b100:  pat = S_RED;
            3'b110:  pat = S_RED_AMBER;
            3'b001:  pat = S_GREEN;
            3'b010:  pat = S_AMBER;
            default: pat_legal = 1'b0;
        endcase
    end

    always_comb begin
        succ = S_UNSYNC;
        case (state)
            S_RED:       succ = S_RED_AMBER;
            S_RED_AMBER: succ = S_GREEN;
            S_GREEN:     succ = S_AMBER;
            S_AMBER:     succ = S_RED;
            default:     succ = S_UNSYNC;
        endcase
    end

    // Error cause for this sample; UNSYNC never reports anything.
    always_comb begin
        cause = E_NONE;
        if (state != S_UNSYNC) begin
            if (!pat_legal)
                cause = E_PATTERN;
            else if (pat == state)
                cause = (dwell == DWELL_MAX) ? E_TIMEOUT : E_NONE;
            else if (pat != succ)
                cause = E_TRANSITION;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_UNSYNC;
            dwell    <= '0;
            cycles   <= '0;
            err      <= 1'b0;
            err_code <= E_NONE;
        end else if (cause != E_NONE) begin
            state <= S_UNSYNC;
            dwell <= '0;
            err   <= 1'b1;
            if (!err)
                err_code <= cause;
        end else if (state == S_UNSYNC) begin
            if (pat_legal)
                state <= pat;
            dwell <= '0;
        end else if (pat == state) begin
            dwell <= dwell + DW_W'(1);
        end else begin
            state <= pat;
            dwell <= '0;
            if (state == S_AMBER)
                cycles <= cycles + CNT_W'(1);
        end
    end

    assign phase = state;

endmodule
